// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared MDU definitions. Holds the RISC-V M-extension funct3
//               encodings and the writeback entry layout {rd, data}.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    // funct3 encodings for the M extension
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Default result width of the datapath
    localparam int MDU_DATA_WIDTH = 32;

    // Writeback entry. The FIFO stores entries in this same {rd, data} order.
    typedef struct packed {
        logic [4:0]                rd;
        logic [MDU_DATA_WIDTH-1:0] data;
    } mdu_wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/mdu_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mdu_wb_fifo
// Description : 2-write / 1-read circular buffer for MDU writebacks.
//               Port 0 (DIV) is written before port 1 (MUL) when both are
//               accepted. When capacity is short, port 1 is dropped first.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               i_push0_*           - DIV entry (valid, rd, data)
//               i_push1_*           - MUL entry (valid, rd, data)
//               i_pop               - remove head entry (ignored when empty)
//               o_head_*            - head entry, zero when empty
//               o_count_next        - occupancy after this cycle's updates
//               o_drop              - a push was refused this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_wb_fifo
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic                              clk,
    input  wire logic                              rst,
    input  wire logic                              i_push0_valid,
    input  wire logic [4:0]                        i_push0_rd,
    input  wire logic [DATA_WIDTH-1:0]             i_push0_data,
    input  wire logic                              i_push1_valid,
    input  wire logic [4:0]                        i_push1_rd,
    input  wire logic [DATA_WIDTH-1:0]             i_push1_data,
    input  wire logic                              i_pop,
    output logic                                   o_head_valid,
    output logic [4:0]                             o_head_rd,
    output logic [DATA_WIDTH-1:0]                  o_head_data,
    output logic [$clog2(FIFO_DEPTH):0]            o_count_next,
    output logic                                   o_drop
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [4:0]            r_rd   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_data [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wptr;
    logic [c_PTR_W-1:0]    r_rptr;
    logic [c_CNT_W-1:0]    r_count;

    logic                  w_pop;
    logic [c_CNT_W-1:0]    w_free;
    logic                  w_acc0;
    logic                  w_acc1;
    logic [c_PTR_W-1:0]    w_wptr1;
    logic [c_CNT_W-1:0]    w_count_next;

    assign w_pop  = i_pop & (r_count != '0);

    // A pop in the same cycle frees its slot for this cycle's pushes.
    assign w_free = c_CNT_W'(FIFO_DEPTH) - r_count + c_CNT_W'(w_pop);

    // DIV only needs one free slot; MUL needs a slot beyond the DIV entry.
    assign w_acc0 = i_push0_valid & (w_free != '0);
    assign w_acc1 = i_push1_valid &
                    (i_push0_valid ? (w_free >= c_CNT_W'(2)) : (w_free != '0));

    assign w_wptr1      = r_wptr + c_PTR_W'(w_acc0);
    assign w_count_next = r_count + c_CNT_W'(w_acc0) + c_CNT_W'(w_acc1)
                          - c_CNT_W'(w_pop);

    assign o_drop       = (i_push0_valid & ~w_acc0) | (i_push1_valid & ~w_acc1);
    assign o_count_next = w_count_next;

    assign o_head_valid = (r_count != '0);
    assign o_head_rd    = o_head_valid ? r_rd[r_rptr]   : 5'd0;
    assign o_head_data  = o_head_valid ? r_data[r_rptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + c_PTR_W'(w_acc0) + c_PTR_W'(w_acc1);
            r_rptr  <= r_rptr + c_PTR_W'(w_pop);
            r_count <= w_count_next;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_acc0) begin
            r_rd[r_wptr]   <= i_push0_rd;
            r_data[r_wptr] <= i_push0_data;
        end
        if (w_acc1) begin
            r_rd[w_wptr1]   <= i_push1_rd;
            r_data[w_wptr1] <= i_push1_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdu_wb_merge.sv
`default_nettype none
// ============================================================================
// Module      : mdu_wb_merge
// Description : Merges MUL and DIV completions into a single register-file
//               writeback stream. Selects the architectural result word,
//               discards x0 writes, buffers in mdu_wb_fifo and drains one
//               entry per cycle under wb_valid/wb_ready.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               mul_done_*, mul_product        - MUL completion
//               div_done_*, div_quot, div_rem  - DIV/REM completion
//               wb_ready / wb_valid, wb_rd, wb_data - writeback handshake
//               stall_issue         - registered hint to hold MDU issue
//               overflow            - sticky: a completion was dropped
// Options     : MDU_WB_BYPASS_EN - when defined, a completion arriving at an
//               empty buffer is presented on wb_* in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_wb_merge
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int STALL_THRESH = 2
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    mul_done_valid,
    input  wire logic [2:0]              mul_done_funct3,
    input  wire logic [4:0]              mul_done_rd,
    input  wire logic [2*DATA_WIDTH-1:0] mul_product,
    input  wire logic                    div_done_valid,
    input  wire logic [2:0]              div_done_funct3,
    input  wire logic [4:0]              div_done_rd,
    input  wire logic [DATA_WIDTH-1:0]   div_quot,
    input  wire logic [DATA_WIDTH-1:0]   div_rem,
    input  wire logic                    wb_ready,
    output logic                         wb_valid,
    output logic [4:0]                   wb_rd,
    output logic [DATA_WIDTH-1:0]        wb_data,
    output logic                         stall_issue,
    output logic                         overflow
);

    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                  w_mul_push;
    logic                  w_div_push;
    logic [DATA_WIDTH-1:0] w_mul_data;
    logic [DATA_WIDTH-1:0] w_div_data;
    logic                  w_fifo_push0;
    logic                  w_fifo_push1;
    logic                  w_fifo_pop;
    logic                  w_head_valid;
    logic [4:0]            w_head_rd;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic                  w_show_head;
    logic [c_CNT_W-1:0]    w_count_next;
    logic                  w_drop;
    logic [31:0]           w_free_next;
    logic                  r_stall_issue;
    logic                  r_overflow;

    // Result select; MULH/MULHSU/MULHU all return the upper product word.
    assign w_mul_data = (mul_done_funct3 == F3_MUL) ? mul_product[DATA_WIDTH-1:0]
                                                     : mul_product[2*DATA_WIDTH-1:DATA_WIDTH];
    assign w_div_data = ((div_done_funct3 == F3_REM) || (div_done_funct3 == F3_REMU))
                        ? div_rem : div_quot;

    // Writes to x0 have no architectural effect and never occupy the buffer.
    assign w_mul_push = mul_done_valid & (mul_done_rd != 5'd0);
    assign w_div_push = div_done_valid & (div_done_rd != 5'd0);

    // The buffer head is hidden while reset is asserted so nothing retires
    // in the reset cycle.
    assign w_show_head = w_head_valid & ~rst;

`ifdef MDU_WB_BYPASS_EN
    logic                  r_post_rst;
    logic                  w_byp_en;
    logic                  w_byp_take;
    logic [4:0]            w_byp_rd;
    logic [DATA_WIDTH-1:0] w_byp_data;

    // Blocks the same-cycle path during reset and the cycle right after it.
    always_ff @(posedge clk) begin
        r_post_rst <= rst;
    end

    // DIV wins the bypass slot when both complete; MUL then goes to the buffer.
    assign w_byp_en   = ~rst & ~r_post_rst & ~w_head_valid & (w_div_push | w_mul_push);
    assign w_byp_rd   = w_div_push ? div_done_rd : mul_done_rd;
    assign w_byp_data = w_div_push ? w_div_data  : w_mul_data;
    assign w_byp_take = w_byp_en & wb_ready;

    assign w_fifo_push0 = w_div_push & ~(w_byp_take & w_div_push);
    assign w_fifo_push1 = w_mul_push & ~(w_byp_take & ~w_div_push);

    assign wb_valid = w_show_head | w_byp_en;
    assign wb_rd    = w_show_head ? w_head_rd   : (w_byp_en ? w_byp_rd   : 5'd0);
    assign wb_data  = w_show_head ? w_head_data : (w_byp_en ? w_byp_data : '0);
`else
    assign w_fifo_push0 = w_div_push;
    assign w_fifo_push1 = w_mul_push;

    assign wb_valid = w_show_head;
    assign wb_rd    = w_show_head ? w_head_rd   : 5'd0;
    assign wb_data  = w_show_head ? w_head_data : '0;
`endif

    assign w_fifo_pop = w_show_head & wb_ready;

    mdu_wb_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .i_push0_valid (w_fifo_push0),
        .i_push0_rd    (div_done_rd),
        .i_push0_data  (w_div_data),
        .i_push1_valid (w_fifo_push1),
        .i_push1_rd    (mul_done_rd),
        .i_push1_data  (w_mul_data),
        .i_pop         (w_fifo_pop),
        .o_head_valid  (w_head_valid),
        .o_head_rd     (w_head_rd),
        .o_head_data   (w_head_data),
        .o_count_next  (w_count_next),
        .o_drop        (w_drop)
    );

    assign w_free_next = 32'(FIFO_DEPTH) - 32'(w_count_next);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_issue <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_stall_issue <= (w_free_next <= 32'(STALL_THRESH));
            r_overflow    <= r_overflow | w_drop;
        end
    end

    assign stall_issue = r_stall_issue;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_mdu_wb_merge.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_wb_merge
// Description : Self-checking bench for mdu_wb_merge (default parameters:
//               32-bit data, depth 4, stall threshold 2). Expected writebacks
//               are queued as stimulus is issued and popped by a monitor on
//               every accepted writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_wb_merge;

    logic        clk;
    logic        rst;
    logic        mul_done_valid;
    logic [2:0]  mul_done_funct3;
    logic [4:0]  mul_done_rd;
    logic [63:0] mul_product;
    logic        div_done_valid;
    logic [2:0]  div_done_funct3;
    logic [4:0]  div_done_rd;
    logic [31:0] div_quot;
    logic [31:0] div_rem;
    logic        wb_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall_issue;
    logic        overflow;

    logic [36:0] sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_wb     = 0;
    int          wb_mark  = 0;

    mdu_wb_merge dut (
        .clk             (clk),
        .rst             (rst),
        .mul_done_valid  (mul_done_valid),
        .mul_done_funct3 (mul_done_funct3),
        .mul_done_rd     (mul_done_rd),
        .mul_product     (mul_product),
        .div_done_valid  (div_done_valid),
        .div_done_funct3 (div_done_funct3),
        .div_done_rd     (div_done_rd),
        .div_quot        (div_quot),
        .div_rem         (div_rem),
        .wb_ready        (wb_ready),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data),
        .stall_issue     (stall_issue),
        .overflow        (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge and clear the done pulses.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        mul_done_valid = 1'b0;
        div_done_valid = 1'b0;
    endtask

    task automatic set_mul(input logic [2:0] f3, input logic [4:0] rd, input logic [63:0] p);
        mul_done_valid  = 1'b1;
        mul_done_funct3 = f3;
        mul_done_rd     = rd;
        mul_product     = p;
    endtask

    task automatic set_div(input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] q, input logic [31:0] r);
        div_done_valid  = 1'b1;
        div_done_funct3 = f3;
        div_done_rd     = rd;
        div_quot        = q;
        div_rem         = r;
    endtask

    // Scoreboard monitor: every accepted writeback must match the oldest
    // outstanding expectation.
    always @(negedge clk) begin
        if (!rst && wb_valid && wb_ready) begin
            logic [36:0] exp_e;
            n_wb++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: actual rd=%0d data=%h required no writeback",
                         wb_rd, wb_data);
            end else begin
                exp_e = sb.pop_front();
                if ({wb_rd, wb_data} !== exp_e) begin
                    n_fail++;
                    $display("FAIL wb_entry: actual rd=%0d data=%h required rd=%0d data=%h",
                             wb_rd, wb_data, exp_e[36:32], exp_e[31:0]);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; wb_ready = 1'b0;
        mul_done_valid = 1'b0; mul_done_funct3 = 3'd0; mul_done_rd = 5'd0; mul_product = 64'd0;
        div_done_valid = 1'b0; div_done_funct3 = 3'd0; div_done_rd = 5'd0;
        div_quot = 32'd0; div_rem = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_wb_valid",    wb_valid,    0);
        chk("rst_wb_rd",       wb_rd,       0);
        chk("rst_wb_data",     wb_data,     0);
        chk("rst_stall_issue", stall_issue, 0);
        chk("rst_overflow",    overflow,    0);

        // MUL low word, then high word
        next_cycle();
        wb_ready = 1'b1;
        set_mul(3'b000, 5'd5, 64'h00000001_00000002);
        sb.push_back({5'd5, 32'h00000002});
`ifndef MDU_WB_BYPASS_EN
        @(negedge clk);
        chk("mul_lat_same_cycle", wb_valid, 0);
`endif
        next_cycle();
`ifndef MDU_WB_BYPASS_EN
        @(negedge clk);
        chk("mul_lat_next_cycle", wb_valid, 1);
`endif
        next_cycle();
        set_mul(3'b011, 5'd5, 64'h00000001_00000002);
        sb.push_back({5'd5, 32'h00000001});
        next_cycle();
        next_cycle();

        // Same-cycle DIV remainder and MUL: DIV retires first
        set_div(3'b110, 5'd7, 32'h00000099, 32'h00000003);
        set_mul(3'b000, 5'd8, 64'hFFFF0000_00000010);
        sb.push_back({5'd7, 32'h00000003});
        sb.push_back({5'd8, 32'h00000010});
        next_cycle();
`ifndef MDU_WB_BYPASS_EN
        @(negedge clk);
        chk("dual_stall_two_free", stall_issue, 1);
`endif
        repeat (3) next_cycle();

        // x0 destination is discarded
        set_mul(3'b000, 5'd0, 64'h12345678_9ABCDEF0);
        next_cycle();
        @(negedge clk);
        chk("x0_wb_valid", wb_valid,    0);
        chk("x0_overflow", overflow,    0);
        chk("x0_stall",    stall_issue, 0);

        // Backpressure: fill, overflow, then drain in order
        next_cycle();
        wb_ready = 1'b0;
        set_div(3'b100, 5'd1, 32'h00000011, 32'hDEAD0000);
        set_mul(3'b001, 5'd2, 64'h00000022_0000BEEF);
        sb.push_back({5'd1, 32'h00000011});
        sb.push_back({5'd2, 32'h00000022});
        next_cycle();
        set_div(3'b111, 5'd3, 32'hCAFE0000, 32'h00000033);
        set_mul(3'b000, 5'd4, 64'h0000F00D_00000044);
        sb.push_back({5'd3, 32'h00000033});
        sb.push_back({5'd4, 32'h00000044});
        @(negedge clk);
        chk("bp_stall_two_free", stall_issue, 1);
        next_cycle();
        set_mul(3'b000, 5'd9, 64'h00000000_00000099);
        @(negedge clk);
        chk("bp_full_wb_valid", wb_valid,    1);
        chk("bp_full_overflow", overflow,    0);
        chk("bp_full_stall",    stall_issue, 1);
        next_cycle();
        @(negedge clk);
        chk("bp_drop_overflow", overflow, 1);
        repeat (3) next_cycle();
        @(negedge clk);
        chk("bp_overflow_sticky", overflow, 1);
        next_cycle();
        wb_mark  = n_wb;
        wb_ready = 1'b1;
        repeat (6) next_cycle();
        @(negedge clk);
        chk("bp_drain_count",    n_wb - wb_mark, 4);
        chk("bp_drain_empty",    wb_valid,       0);
        chk("bp_drain_overflow", overflow,       1);
        chk("bp_drain_stall",    stall_issue,    0);

        // Full + pop + one push, then reset mid-drain
        next_cycle();
        wb_ready = 1'b0;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        set_div(3'b100, 5'd10, 32'h000000A0, 32'h0);
        set_mul(3'b000, 5'd11, 64'h0_000000B0);
        sb.push_back({5'd10, 32'h000000A0});
        sb.push_back({5'd11, 32'h000000B0});
        next_cycle();
        set_div(3'b110, 5'd12, 32'h0, 32'h000000C0);
        set_mul(3'b011, 5'd13, 64'h000000D0_00000000);
        sb.push_back({5'd12, 32'h000000C0});
        sb.push_back({5'd13, 32'h000000D0});
        next_cycle();
        wb_ready = 1'b1;
        set_mul(3'b000, 5'd14, 64'h0_000000E0);
        sb.push_back({5'd14, 32'h000000E0});
        next_cycle();
        wb_ready = 1'b0;
        @(negedge clk);
        chk("fullpop_overflow", overflow,    0);
        chk("fullpop_wb_valid", wb_valid,    1);
        chk("fullpop_stall",    stall_issue, 1);
        next_cycle();
        wb_ready = 1'b1;
        next_cycle();
        wb_ready = 1'b0;
        rst = 1'b1;
        sb.delete();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_wb_valid", wb_valid,    0);
        chk("midrst_overflow", overflow,    0);
        chk("midrst_stall",    stall_issue, 0);
        next_cycle();
        wb_ready = 1'b1;
        repeat (4) next_cycle();

`ifdef MDU_WB_BYPASS_EN
        // Same-cycle presentation from an empty buffer
        set_div(3'b100, 5'd3, 32'h00000055, 32'h0);
        sb.push_back({5'd3, 32'h00000055});
        @(negedge clk);
        chk("byp_wb_valid", wb_valid, 1);
        chk("byp_wb_data",  wb_data,  32'h55);
        next_cycle();
        @(negedge clk);
        chk("byp_fifo_empty", wb_valid, 0);
        next_cycle();
`endif

        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
